// File: rtl/fixed_patch_unembed_pkg.sv
// Shared constants and helpers for the patch un-embedding stage.
package fixed_patch_unembed_pkg;

   localparam int unsigned NUM_BANKS = 2;

   // Counter/address width for a range of n values, never narrower than 1 bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fixed_patch_unembed_band_buffer.sv
// Two-bank band store: one write port, one registered read port.
module unembed_band_buffer
   import fixed_patch_unembed_pkg::*;
#(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_we,
   input  logic                       i_wbank,
   input  logic [cnt_w(DEPTH)-1:0]    i_waddr,
   input  logic [WIDTH-1:0]           i_wdata,
   input  logic                       i_re,
   input  logic                       i_rbank,
   input  logic [cnt_w(DEPTH)-1:0]    i_raddr,
   output logic [WIDTH-1:0]           o_rdata
);

   localparam int unsigned AW    = cnt_w(DEPTH);
   localparam int unsigned WORDS = NUM_BANKS * (1 << AW);

   logic [WIDTH-1:0] r_mem [WORDS];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[{i_wbank, i_waddr}] <= i_wdata;
      end
   end

   // Read register doubles as the stage output register; it holds when no read is issued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         o_rdata <= '0;
      end else if (i_re) begin
         o_rdata <= r_mem[{i_rbank, i_raddr}];
      end
   end

endmodule

// File: rtl/fixed_patch_unembed.sv
// Reorders patch-ordered beats into a raster-ordered stream via a ping-pong band buffer.
module fixed_patch_unembed
   import fixed_patch_unembed_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 6,
   parameter int unsigned C          = 4,
   parameter int unsigned IMG_Y      = 16,
   parameter int unsigned IMG_X      = 16,
   parameter int unsigned PATCH_SIZE = 2,
   parameter int unsigned UNROLL_C   = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [UNROLL_C*DATA_WIDTH-1:0] data_in_0,
   input  logic                           data_in_0_valid,
   output logic                           data_in_0_ready,
   output logic [UNROLL_C*DATA_WIDTH-1:0] data_out_0,
   output logic                           data_out_0_valid,
   input  logic                           data_out_0_ready
);

   localparam int unsigned C_BEATS    = C / UNROLL_C;
   localparam int unsigned NP_X       = IMG_X / PATCH_SIZE;
   localparam int unsigned NP_Y       = IMG_Y / PATCH_SIZE;
   localparam int unsigned BANK_DEPTH = PATCH_SIZE * IMG_X * C_BEATS;
   localparam int unsigned BW         = UNROLL_C * DATA_WIDTH;
   localparam int unsigned AW         = cnt_w(BANK_DEPTH);
   localparam int unsigned CB_W       = cnt_w(C_BEATS);
   localparam int unsigned K_W        = cnt_w(PATCH_SIZE);
   localparam int unsigned PX_W       = cnt_w(NP_X);
   localparam int unsigned PY_W       = cnt_w(NP_Y);

   logic [CB_W-1:0] r_cb;
   logic [K_W-1:0]  r_kx;
   logic [K_W-1:0]  r_ky;
   logic [PX_W-1:0] r_px;
   logic [PY_W-1:0] r_py;
   logic            r_wsel;
   logic            r_rsel;
   logic [1:0]      r_full;
   logic [AW-1:0]   r_raddr;
   logic            r_ovalid;

   logic            w_wr;
   logic            w_rd;
   logic            w_cb_last;
   logic            w_kx_last;
   logic            w_ky_last;
   logic            w_px_last;
   logic            w_py_last;
   logic            w_band_last;
   logic            w_rd_last;
   logic [AW-1:0]   w_waddr;
   logic [1:0]      w_set_vec;
   logic [1:0]      w_clr_vec;

   assign data_in_0_ready  = ~r_full[r_wsel];
   assign data_out_0_valid = r_ovalid;

   assign w_wr = data_in_0_valid & data_in_0_ready;
   assign w_rd = r_full[r_rsel] & (~r_ovalid | data_out_0_ready);

   assign w_cb_last   = (r_cb == CB_W'(C_BEATS - 1));
   assign w_kx_last   = (r_kx == K_W'(PATCH_SIZE - 1));
   assign w_ky_last   = (r_ky == K_W'(PATCH_SIZE - 1));
   assign w_px_last   = (r_px == PX_W'(NP_X - 1));
   assign w_py_last   = (r_py == PY_W'(NP_Y - 1));
   assign w_band_last = w_cb_last & w_kx_last & w_ky_last & w_px_last;
   assign w_rd_last   = (r_raddr == AW'(BANK_DEPTH - 1));

   // Band-relative raster offset of the current patch-ordered beat.
   always_comb begin
      w_waddr = AW'((((32'(r_ky) * IMG_X) + (32'(r_px) * PATCH_SIZE) + 32'(r_kx)) * C_BEATS)
                    + 32'(r_cb));
   end

   always_comb begin
      w_set_vec = 2'b00;
      w_clr_vec = 2'b00;
      if (w_wr && w_band_last) begin
         w_set_vec = r_wsel ? 2'b10 : 2'b01;
      end
      if (w_rd && w_rd_last) begin
         w_clr_vec = r_rsel ? 2'b10 : 2'b01;
      end
   end

   // Patch-order write counters, innermost cb.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cb <= '0;
         r_kx <= '0;
         r_ky <= '0;
         r_px <= '0;
         r_py <= '0;
      end else if (w_wr) begin
         r_cb <= w_cb_last ? '0 : r_cb + CB_W'(1);
         if (w_cb_last) begin
            r_kx <= w_kx_last ? '0 : r_kx + K_W'(1);
            if (w_kx_last) begin
               r_ky <= w_ky_last ? '0 : r_ky + K_W'(1);
               if (w_ky_last) begin
                  r_px <= w_px_last ? '0 : r_px + PX_W'(1);
                  if (w_px_last) begin
                     r_py <= w_py_last ? '0 : r_py + PY_W'(1);
                  end
               end
            end
         end
      end
   end

   // Bank ownership: writer and reader each flip only their own bank's flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_full <= 2'b00;
         r_wsel <= 1'b0;
         r_rsel <= 1'b0;
      end else begin
         r_full <= (r_full & ~w_clr_vec) | w_set_vec;
         if (|w_set_vec) begin
            r_wsel <= ~r_wsel;
         end
         if (|w_clr_vec) begin
            r_rsel <= ~r_rsel;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_raddr  <= '0;
         r_ovalid <= 1'b0;
      end else begin
         if (w_rd) begin
            r_raddr <= w_rd_last ? '0 : r_raddr + AW'(1);
         end
         if (w_rd) begin
            r_ovalid <= 1'b1;
         end else if (data_out_0_ready) begin
            r_ovalid <= 1'b0;
         end
      end
   end

   unembed_band_buffer #(
      .WIDTH (BW),
      .DEPTH (BANK_DEPTH)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr),
      .i_wbank (r_wsel),
      .i_waddr (w_waddr),
      .i_wdata (data_in_0),
      .i_re    (w_rd),
      .i_rbank (r_rsel),
      .i_raddr (r_raddr),
      .o_rdata (data_out_0)
   );

endmodule

// File: tb/tb_fixed_patch_unembed.sv
// Scoreboard bench for fixed_patch_unembed with 16-bit elements on a 16x16x4 image.
module tb_fixed_patch_unembed;

   localparam int unsigned DW = 16;
   localparam int unsigned BW = 2 * DW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [BW-1:0] data_in_0 = '0;
   logic          data_in_0_valid = 1'b0;
   logic          data_in_0_ready;
   logic [BW-1:0] data_out_0;
   logic          data_out_0_valid;
   logic          data_out_0_ready = 1'b1;

   int            cyc = 0;
   int            checks = 0;
   int            passes = 0;
   int            pops = 0;
   int            in_idx = 0;
   int            t_hs0 = -1;
   int            rdy_mode = 1;
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] out_log [0:4095];
   int            pop_cyc [0:4095];

   fixed_patch_unembed #(.DATA_WIDTH(DW)) dut (
      .clk              (clk),
      .rst              (rst),
      .data_in_0        (data_in_0),
      .data_in_0_valid  (data_in_0_valid),
      .data_in_0_ready  (data_in_0_ready),
      .data_out_0       (data_out_0),
      .data_out_0_valid (data_out_0_valid),
      .data_out_0_ready (data_out_0_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Beat holding channels 2cb, 2cb+1 of pixel (ky,kx) inside patch p.
   function automatic logic [BW-1:0] pix(input int p, input int ky, input int kx, input int cb);
      int v0;
      v0 = 2 * cb + 4 * (ky * 2 + kx) + 16 * p;
      return {16'(v0 + 1), 16'(v0)};
   endfunction

   function automatic logic [BW-1:0] in_beat(input int i);
      return pix((i / 8) % 64, (i / 4) % 2, (i / 2) % 2, i % 2);
   endfunction

   // Software unpatchify of one band: raster rows 2b, 2b+1.
   task automatic push_band(input int b);
      for (int y = 2 * b; y < 2 * b + 2; y++)
         for (int x = 0; x < 16; x++)
            for (int cb = 0; cb < 2; cb++)
               exp_q.push_back(pix((y / 2) * 8 + x / 2, y % 2, x % 2, cb));
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       data_out_0_ready = 1'b0;
         2:       data_out_0_ready = 1'($urandom_range(0, 1));
         default: data_out_0_ready = 1'b1;
      endcase
   end

   // Monitor: pop and compare on every output handshake.
   always @(negedge clk) begin
      if (rst && data_out_0_valid && data_out_0_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL spurious_beat: got %0h expected none", data_out_0);
         end else begin
            chk($sformatf("beat%0d", pops), 64'(data_out_0), 64'(exp_q.pop_front()));
         end
         if (pops < 4096) begin
            out_log[pops] = data_out_0;
            pop_cyc[pops] = cyc;
         end
         pops++;
      end
   end

   task automatic send(input int n, input bit gaps, input int budget, output int sent);
      bit acc;
      int tc;
      int spent;
      sent  = 0;
      spent = 0;
      while (sent < n && spent < budget) begin
         data_in_0       = in_beat(in_idx);
         data_in_0_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge clk);
         acc = data_in_0_valid && data_in_0_ready;
         tc  = cyc;
         @(posedge clk);
         #1;
         spent++;
         if (acc) begin
            if (in_idx % 512 == 63 && t_hs0 < 0) t_hs0 = tc;
            if (in_idx % 64 == 63) push_band((in_idx / 64) % 8);
            in_idx++;
            sent++;
         end
      end
      data_in_0_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      repeat (5) @(posedge clk);
      #1;
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int s;
      int base;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(data_out_0_valid), 64'd0);
      chk("rst_ready", 64'(data_in_0_ready), 64'd1);
      chk("rst_data", 64'(data_out_0), 64'd0);
      rst = 1'b1;

      // Two back-to-back frames at full rate.
      send(1024, 1'b0, 3000, s);
      chk("s1_sent", 64'(s), 64'd1024);
      wait_drain(300);
      chk("s1_pops", 64'(pops), 64'd1024);
      chk("latency", 64'(pop_cyc[0]), 64'(t_hs0 + 2));
      chk("band_burst", 64'(pop_cyc[63]), 64'(pop_cyc[0] + 63));
      chk("first_beat0", 64'(out_log[0]), 64'h0001_0000);
      chk("first_beat1", 64'(out_log[1]), 64'h0003_0002);
      chk("first_beat2", 64'(out_log[2]), 64'h0005_0004);
      chk("first_beat4", 64'(out_log[4]), 64'h0011_0010);
      chk("first_beat6", 64'(out_log[6]), 64'h0015_0014);
      chk("row1_start", 64'(out_log[32]), 64'h0009_0008);
      chk("frame_seam", 64'(pop_cyc[512]), 64'(pop_cyc[511] + 1));

      // Three frames with random valid and ready.
      rdy_mode = 2;
      send(1536, 1'b1, 8000, s);
      chk("s4_sent", 64'(s), 64'd1536);
      rdy_mode = 1;
      wait_drain(400);
      chk("s4_pops", 64'(pops), 64'd2560);

      // Output stalled: two bands fill, then input stalls.
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      send(200, 1'b0, 200, s);
      chk("bp_accepted", 64'(s), 64'd128);
      chk("bp_in_ready", 64'(data_in_0_ready), 64'd0);
      chk("bp_valid", 64'(data_out_0_valid), 64'd1);
      chk("bp_hold_data", 64'(data_out_0), 64'h0001_0000);
      rdy_mode = 1;
      wait_drain(400);
      chk("bp_pops", 64'(pops), 64'd2688);

      // Reset in the middle of a band, then a fresh frame.
      send(40, 1'b0, 100, s);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("mid_rst_valid", 64'(data_out_0_valid), 64'd0);
      chk("mid_rst_ready", 64'(data_in_0_ready), 64'd1);
      in_idx = 0;
      base   = pops;
      send(512, 1'b0, 1500, s);
      chk("s5_sent", 64'(s), 64'd512);
      wait_drain(300);
      chk("s5_pops", 64'(pops - base), 64'd512);
      chk("s5_first", 64'(out_log[base]), 64'h0001_0000);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
